fmeter_gate_ctrl: RTL
=====================

FMETER_GATE_CTRL -- requirements
Module: fmeter_gate_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  - CNT_W, 10, width of the measured count.
  - GATE0, 10, gate length in CLK cycles for GATE_SEL=0.
  - GATE1, 100, gate length in CLK cycles for GATE_SEL=1.
  - GATE2, 1000, gate length in CLK cycles for GATE_SEL=2.
  - GATE3, 10000, gate length in CLK cycles for GATE_SEL=3.
  - TMR_W, 14, gate timer width; must satisfy 2^TMR_W > GATE3.
REQ-002 SHALL have ports (name, direction, width, meaning):
  - CLK, in, 1, clock.
  - RESET, in, 1, reset: asynchronous, active-high.
  - START, in, 1, single-cycle request for one measurement.
  - CONT, in, 1, continuous mode: restart automatically after ACK.
  - ABORT, in, 1, cancel the current measurement.
  - GATE_SEL, in, 2, gate length select.
  - CNT_VALUE, in, CNT_W, live count from the 10-bit saturating event counter.
  - CNT_FULL, in, 1, saturation flag from that counter.
  - CNT_CLR, out, 1, registered clear pulse; drives the counter reset.
  - CNT_GATE, out, 1, registered gate; counter enable = CNT_GATE AND event qualifier.
  - RESULT, out, CNT_W, latched count.
  - OVERFLOW, out, 1, latched saturation flag.
  - VALID, out, 1, RESULT/OVERFLOW valid.
  - ACK, in, 1, consumer has taken the result.
  - BUSY, out, 1, high in any state other than IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, CLEAR, GATE, SETTLE, HOLD.
REQ-004 IDLE: START=1 at edge e0 -> CLEAR; GATE_SEL sampled at e0 and held for the whole measurement.
REQ-005 CLEAR: CNT_CLR=1 for exactly one cycle; next edge e1 -> GATE; gate timer loaded with GATEn-1.
REQ-006 GATE: CNT_GATE=1 for exactly GATEn cycles (edges e1..eN+1); timer counts down; at 0 -> SETTLE.
REQ-007 SETTLE: CNT_GATE=0 for one cycle; at exit edge eN+2 capture RESULT<=CNT_VALUE, OVERFLOW<=CNT_FULL, VALID<=1 -> HOLD.
REQ-008 Latency from START edge e0 to VALID rising SHALL be GATEn+2 edges.
REQ-009 HOLD: VALID, RESULT and OVERFLOW held stable until ACK=1.
REQ-010 ACK=1 in HOLD clears VALID at that edge; next state is CLEAR if CONT=1, else IDLE. An ACK in the first HOLD cycle is accepted.
REQ-011 In continuous mode, GATE_SEL SHALL be resampled on each HOLD->CLEAR transition.
REQ-012 START outside IDLE SHALL be ignored (no queuing). ACK outside HOLD SHALL be ignored.
REQ-013 ABORT=1 in any state SHALL force IDLE at the next edge, with CNT_GATE=0, VALID=0 and RESULT/OVERFLOW unchanged. ABORT has priority over START and ACK in the same cycle.
REQ-014 CNT_CLR and CNT_GATE SHALL never be high in the same cycle, and both SHALL be flop outputs (glitch-free).
REQ-015 OVERFLOW=1 implies RESULT=2^CNT_W-1. No arithmetic is performed on the count.

Reset
REQ-016 RESET=1 SHALL immediately force:
  - state to IDLE and gate timer to 0;
  - CNT_CLR=1 (asynchronously clearing the counter) and CNT_GATE=0;
  - RESULT=0, OVERFLOW=0, VALID=0, BUSY=0.
REQ-017 The first edge after RESET deasserts SHALL drop CNT_CLR to 0. A reset mid-GATE SHALL discard the measurement with no VALID.

Structure
REQ-018 Package fmeter_pkg SHALL hold:
  - the FSM state enumeration;
  - CNT_W and the default GATE0..GATE3 constants;
  - the GATE_SEL encoding.
REQ-019 Sub-module fmeter_gate_timer (loadable TMR_W down-counter with zero flag) SHALL be instantiated once. Everything else stays in fmeter_gate_ctrl.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - GATE_SEL=1, counter fed one qualified event every 4 CLK -> VALID at e0+102, RESULT=25, OVERFLOW=0, CNT_GATE high exactly 100 cycles.
  - GATE_SEL=3, event every cycle -> counter saturates; RESULT=1023, OVERFLOW=1.
  - CONT=1, GATE_SEL=0, ACK in the first HOLD cycle -> CNT_CLR the next cycle, back-to-back results every 13 cycles.
  - ABORT at gate cycle 50 of GATE_SEL=1 -> IDLE next edge, CNT_GATE=0, no VALID, previous RESULT kept.
  - START pulsed during GATE and HOLD -> ignored; exactly one VALID per accepted START.
  - RESET asserted mid-GATE -> all outputs at reset values immediately, CNT_CLR=1; after release, a new START yields a correct measurement.

Source files
------------

// File: rtl/fmeter_pkg.sv
// Shared constants for the frequency-meter gate controller:
// state codes, default gate lengths and the GATE_SEL encoding.
package fmeter_pkg;

    localparam int FM_CNT_W = 10;
    localparam int FM_TMR_W = 14;

    localparam int FM_GATE0 = 10;
    localparam int FM_GATE1 = 100;
    localparam int FM_GATE2 = 1000;
    localparam int FM_GATE3 = 10000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_GATE   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam logic [1:0] GSEL_G0 = 2'd0;
    localparam logic [1:0] GSEL_G1 = 2'd1;
    localparam logic [1:0] GSEL_G2 = 2'd2;
    localparam logic [1:0] GSEL_G3 = 2'd3;

    function automatic int fm_gate_len(
        input logic [1:0] sel,
        input int         g0,
        input int         g1,
        input int         g2,
        input int         g3
    );
        int len;
        case (sel)
            GSEL_G0: len = g0;
            GSEL_G1: len = g1;
            GSEL_G2: len = g2;
            default: len = g3;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fmeter_gate_timer.sv
// Loadable down-counter that times the gate window.
// Stops at zero and flags it; a clear drops it straight to zero.
module fmeter_gate_timer
    import fmeter_pkg::*;
#(
    parameter int TMR_W = FM_TMR_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_count;
    logic             w_zero;

    assign w_zero = (r_count == '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && !w_zero) begin
            r_count <= r_count - TMR_W'(1);
        end
    end

    assign o_zero = w_zero;

endmodule

// File: rtl/fmeter_gate_ctrl.sv
// Gate controller for a frequency meter: clears the external event
// counter, opens a gate of selectable length, then latches the count.
module fmeter_gate_ctrl
    import fmeter_pkg::*;
#(
    parameter int CNT_W = FM_CNT_W,
    parameter int GATE0 = FM_GATE0,
    parameter int GATE1 = FM_GATE1,
    parameter int GATE2 = FM_GATE2,
    parameter int GATE3 = FM_GATE3,
    parameter int TMR_W = FM_TMR_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             CONT,
    input  logic             ABORT,
    input  logic [1:0]       GATE_SEL,
    input  logic [CNT_W-1:0] CNT_VALUE,
    input  logic             CNT_FULL,
    output logic             CNT_CLR,
    output logic             CNT_GATE,
    output logic [CNT_W-1:0] RESULT,
    output logic             OVERFLOW,
    output logic             VALID,
    input  logic             ACK,
    output logic             BUSY
);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [1:0]       r_gsel;
    logic             r_cnt_clr;
    logic             r_cnt_gate;
    logic [CNT_W-1:0] r_result;
    logic             r_ovf;
    logic             r_valid;

    logic             w_tmr_load;
    logic             w_tmr_dec;
    logic             w_tmr_zero;
    logic [TMR_W-1:0] w_load_val;
    logic             w_capture;

    always_comb begin
        w_next = r_state;
        if (ABORT) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) w_next = ST_CLEAR;
                end
                ST_CLEAR: begin
                    w_next = ST_GATE;
                end
                ST_GATE: begin
                    if (w_tmr_zero) w_next = ST_SETTLE;
                end
                ST_SETTLE: begin
                    w_next = ST_HOLD;
                end
                ST_HOLD: begin
                    if (ACK) w_next = CONT ? ST_CLEAR : ST_IDLE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // Timer holds GATEn-1 on the first gate cycle and exits at zero.
    assign w_load_val = TMR_W'(
        fm_gate_len(r_gsel, GATE0, GATE1, GATE2, GATE3) - 1);
    assign w_tmr_load = (r_state == ST_CLEAR);
    assign w_tmr_dec  = (r_state == ST_GATE);
    assign w_capture  = (r_state == ST_SETTLE) && (w_next == ST_HOLD);

    fmeter_gate_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_clr     (ABORT),
        .i_load    (w_tmr_load),
        .i_load_val(w_load_val),
        .i_dec     (w_tmr_dec),
        .o_zero    (w_tmr_zero)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_gsel  <= GSEL_G0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_CLEAR) r_gsel <= GATE_SEL;
        end
    end

    // Strobes decode the next state so they are flops aligned with it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt_clr  <= 1'b1;
            r_cnt_gate <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_cnt_clr  <= (w_next == ST_CLEAR);
            r_cnt_gate <= (w_next == ST_GATE);
            r_valid    <= (w_next == ST_HOLD);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else if (w_capture) begin
            r_result <= CNT_VALUE;
            r_ovf    <= CNT_FULL;
        end
    end

    assign CNT_CLR  = r_cnt_clr;
    assign CNT_GATE = r_cnt_gate;
    assign RESULT   = r_result;
    assign OVERFLOW = r_ovf;
    assign VALID    = r_valid;
    assign BUSY     = (r_state != ST_IDLE);

    a_clr_gate_excl: assert property (
        @(posedge CLK) disable iff (RESET) !(r_cnt_clr && r_cnt_gate));

endmodule
